// File: rtl/riscv_ctrl_datamem.sv
// riscv_ctrl_datamem: ID control decode, EX ALU-select decode and the MEM-stage
// byte-addressed data RAM for the 5-stage RV32I pipeline. Only the RAM holds state.
module riscv_ctrl_datamem #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  // ID stage
  input  logic [31:0] id_inst,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic        mux_rf_sel,
  output logic        auipc_sel,
  output logic [1:0]  save_method,
  output logic        jump,
  output logic        jalr,
  output logic        load_pc,
  // EX stage
  input  logic [31:0] ex_inst,
  input  logic [1:0]  ex_alu_op,
  input  logic        ex_alu_src,
  output logic [3:0]  alu_sel,
  // MEM stage
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [1:0]  dm_save_method,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_SYSTEM = 7'b1110011,
    OP_FENCE  = 7'b0001111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_PASSB = 4'b0011,
    ALU_OR    = 4'b0100,
    ALU_AND   = 4'b0101,
    ALU_XOR   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SLL   = 4'b1001,
    ALU_SRA   = 4'b1010,
    ALU_SLT   = 4'b1101,
    ALU_SLTU  = 4'b1111
  } alu_sel_e;

  // Store width encodings shared by the decoder and the RAM write path.
  localparam logic [1:0] SM_WORD = 2'b00;
  localparam logic [1:0] SM_HALF = 2'b01;
  localparam logic [1:0] SM_BYTE = 2'b10;

  // Instruction fields this block never looks at.
  logic unused_bits;
  assign unused_bits = ^{id_inst[31:15], id_inst[11:7], ex_inst[31], ex_inst[29:15],
                         ex_inst[11:7], dm_addr[31:ADDR_W]};

  // ID control decode from the opcode (store width also needs funct3).
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves
    // one unassigned, which would otherwise infer a latch.
    branch      = 1'b0;
    mem_read    = 1'b0;
    mem_to_reg  = 1'b0;
    mem_write   = 1'b0;
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    alu_op      = 2'b00;
    mux_rf_sel  = 1'b1;
    auipc_sel   = 1'b0;
    save_method = SM_WORD;
    jump        = 1'b0;
    jalr        = 1'b0;
    load_pc     = 1'b1;
    case (id_inst[6:0])
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b11;
      end
      OP_LOAD: begin
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        alu_src    = 1'b1;
      end
      OP_STORE: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
        case (id_inst[14:12])
          3'b000:  save_method = SM_BYTE;
          3'b001:  save_method = SM_HALF;
          default: save_method = SM_WORD;
        endcase
      end
      OP_BRANCH: begin
        branch = 1'b1;
        alu_op = 2'b01;
      end
      OP_JAL: begin
        jump      = 1'b1;
        reg_write = 1'b1;
        auipc_sel = 1'b1;
      end
      OP_JALR: begin
        jump      = 1'b1;
        jalr      = 1'b1;
        reg_write = 1'b1;
        auipc_sel = 1'b1;
        alu_src   = 1'b1;
      end
      OP_LUI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_AUIPC: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mux_rf_sel = 1'b0;
      end
      OP_SYSTEM, OP_FENCE: begin
        // Halting instructions freeze the PC.
        mux_rf_sel = 1'b0;
        load_pc    = 1'b0;
      end
      default: begin
        // Unknown opcodes become a bubble but the PC keeps advancing.
        mux_rf_sel = 1'b0;
      end
    endcase
  end

  // EX ALU function select from ALUOp, funct3 and bit 30.
  always_comb begin
    alu_sel_e sel;
    sel = ALU_ADD;
    case (ex_alu_op)
      2'b00: sel = (ex_inst[6:0] == OP_LUI) ? ALU_PASSB : ALU_ADD;
      2'b01: sel = ALU_SUB;
      default: begin
        case (ex_inst[14:12])
          // Bit 30 of an I-type is immediate data, so SUB needs R-type with a register B.
          3'b000:  sel = (ex_alu_op == 2'b10 && ex_inst[30] && !ex_alu_src) ? ALU_SUB : ALU_ADD;
          3'b001:  sel = ALU_SLL;
          3'b010:  sel = ALU_SLT;
          3'b011:  sel = ALU_SLTU;
          3'b100:  sel = ALU_XOR;
          3'b101:  sel = ex_inst[30] ? ALU_SRA : ALU_SRL;
          3'b110:  sel = ALU_OR;
          default: sel = ALU_AND;
        endcase
      end
    endcase
    alu_sel = sel;
  end

  // Byte lanes of the access; each wraps around the top of the RAM.
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  assign a0 = dm_addr[ADDR_W-1:0];
  assign a1 = a0 + ADDR_W'(1);
  assign a2 = a0 + ADDR_W'(2);
  assign a3 = a0 + ADDR_W'(3);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];

  // Next RAM contents: merge the enabled store bytes into the current array.
  always_comb begin
    mem_d = mem_q;
    if (dm_write) begin
      mem_d[a0] = dm_wdata[7:0];
      if (dm_save_method != SM_BYTE) begin
        mem_d[a1] = dm_wdata[15:8];
      end
      if (dm_save_method == SM_WORD || dm_save_method == 2'b11) begin
        mem_d[a2] = dm_wdata[23:16];
        mem_d[a3] = dm_wdata[31:24];
      end
    end
  end

  // RAM state: cleared asynchronously by reset, otherwise updated each rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the array is reset on purpose -- software expects zeroed data memory,
      // so this is built from flops rather than a reset-less RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      // NOTE: state updates use non-blocking assignment so every flop samples
      // pre-edge values and simulation matches the synthesized registers.
      mem_q <= mem_d;
    end
  end

  // Combinational little-endian read, forced to zero when idle or in reset.
  always_comb begin
    dm_rdata = 32'h0;
    if (dm_read && rst) begin
      dm_rdata = {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[a0]};
    end
  end

endmodule

// File: tb/tb_riscv_ctrl_datamem.sv
// Self-checking bench for riscv_ctrl_datamem: expected values are queued as
// stimulus is driven, observed values are queued when sampled, then paired up.
module tb_riscv_ctrl_datamem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] id_inst = 32'h0;
  logic        branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]  alu_op;
  logic        mux_rf_sel, auipc_sel;
  logic [1:0]  save_method;
  logic        jump, jalr, load_pc;
  logic [31:0] ex_inst = 32'h0;
  logic [1:0]  ex_alu_op = 2'b00;
  logic        ex_alu_src = 1'b0;
  logic [3:0]  alu_sel;
  logic        dm_read = 1'b0;
  logic        dm_write = 1'b0;
  logic [1:0]  dm_save_method = 2'b00;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic [31:0] dm_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } item_t;

  item_t exp_q[$];
  item_t obs_q[$];

  always #5 clk = ~clk;

  riscv_ctrl_datamem #(.ADDR_W(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_inst        (id_inst),
    .branch         (branch),
    .mem_read       (mem_read),
    .mem_to_reg     (mem_to_reg),
    .mem_write      (mem_write),
    .alu_src        (alu_src),
    .reg_write      (reg_write),
    .alu_op         (alu_op),
    .mux_rf_sel     (mux_rf_sel),
    .auipc_sel      (auipc_sel),
    .save_method    (save_method),
    .jump           (jump),
    .jalr           (jalr),
    .load_pc        (load_pc),
    .ex_inst        (ex_inst),
    .ex_alu_op      (ex_alu_op),
    .ex_alu_src     (ex_alu_src),
    .alu_sel        (alu_sel),
    .dm_read        (dm_read),
    .dm_write       (dm_write),
    .dm_save_method (dm_save_method),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_rdata       (dm_rdata)
  );

  function automatic item_t mk(input string nm, input logic [31:0] v);
    item_t it;
    it.name = nm;
    it.val  = v;
    return it;
  endfunction

  // Packed control vector: {branch,mem_read,mem_to_reg,mem_write,alu_src,reg_write,
  // alu_op,mux_rf_sel,auipc_sel,save_method,jump,jalr,load_pc}.
  function automatic logic [14:0] ctl(input logic b, mr, mtr, mw, asrc, rw,
                                      input logic [1:0] aop, input logic mux, ap,
                                      input logic [1:0] sm, input logic j, jr, lpc);
    return {b, mr, mtr, mw, asrc, rw, aop, mux, ap, sm, j, jr, lpc};
  endfunction

  task automatic ram_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] sm);
    @(negedge clk);
    dm_read        = 1'b0;
    dm_write       = 1'b1;
    dm_addr        = addr;
    dm_wdata       = data;
    dm_save_method = sm;
    @(posedge clk);
    #1;
    dm_write = 1'b0;
  endtask

  task automatic ram_read(input string nm, input logic [31:0] addr,
                          input logic [31:0] exp_val);
    @(negedge clk);
    dm_write = 1'b0;
    dm_read  = 1'b1;
    dm_addr  = addr;
    exp_q.push_back(mk(nm, exp_val));
    #1;
    obs_q.push_back(mk(nm, dm_rdata));
  endtask

  task automatic test_reset();
    item_t e, o;
    rst      = 1'b0;
    dm_read  = 1'b1;
    dm_addr  = 32'h0;
    exp_q.push_back(mk("reset_rdata", 32'h0));
    #1;
    obs_q.push_back(mk("reset_rdata", dm_rdata));
    // A write attempted while reset is held must not land.
    @(negedge clk);
    dm_write = 1'b1;
    dm_wdata = 32'hFFFF_FFFF;
    dm_save_method = 2'b00;
    @(posedge clk);
    @(negedge clk);
    dm_write = 1'b0;
    #1 rst = 1'b1;
    ram_read("write_in_reset", 32'h0, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no observation, expected %h", e.name, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.val !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
        end
      end
    end
  endtask

  task automatic test_decode();
    item_t e, o;
    logic [31:0] insts [15];
    logic [14:0] exps  [15];
    insts = '{32'h002081B3, 32'h402081B3, 32'h12345237, 32'h00000073, 32'h0000006F,
              32'h00208023, 32'h00209023, 32'h0020A023, 32'h0000A083, 32'h00208463,
              32'h000080E7, 32'h00000097, 32'hFFF00093, 32'h0000000F, 32'h0000007F};
    exps = '{
      ctl(0,0,0,0,0,1,2'b10,1,0,2'b00,0,0,1),  // add
      ctl(0,0,0,0,0,1,2'b10,1,0,2'b00,0,0,1),  // sub
      ctl(0,0,0,0,1,1,2'b00,1,0,2'b00,0,0,1),  // lui
      ctl(0,0,0,0,0,0,2'b00,0,0,2'b00,0,0,0),  // ecall
      ctl(0,0,0,0,0,1,2'b00,1,1,2'b00,1,0,1),  // jal
      ctl(0,0,0,1,1,0,2'b00,1,0,2'b10,0,0,1),  // sb
      ctl(0,0,0,1,1,0,2'b00,1,0,2'b01,0,0,1),  // sh
      ctl(0,0,0,1,1,0,2'b00,1,0,2'b00,0,0,1),  // sw
      ctl(0,1,1,0,1,1,2'b00,1,0,2'b00,0,0,1),  // lw
      ctl(1,0,0,0,0,0,2'b01,1,0,2'b00,0,0,1),  // beq
      ctl(0,0,0,0,1,1,2'b00,1,1,2'b00,1,1,1),  // jalr
      ctl(0,0,0,0,1,1,2'b00,0,0,2'b00,0,0,1),  // auipc
      ctl(0,0,0,0,1,1,2'b11,1,0,2'b00,0,0,1),  // addi
      ctl(0,0,0,0,0,0,2'b00,0,0,2'b00,0,0,0),  // fence
      ctl(0,0,0,0,0,0,2'b00,0,0,2'b00,0,0,1)   // unknown opcode
    };
    for (int i = 0; i < 15; i++) begin
      id_inst = insts[i];
      exp_q.push_back(mk($sformatf("decode[%0d]", i), {17'b0, exps[i]}));
      #1;
      obs_q.push_back(mk($sformatf("decode[%0d]", i),
                         {17'b0, branch, mem_read, mem_to_reg, mem_write, alu_src,
                          reg_write, alu_op, mux_rf_sel, auipc_sel, save_method,
                          jump, jalr, load_pc}));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no observation, expected %h", e.name, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.val !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
        end
      end
    end
  endtask

  task automatic test_alu_sel();
    item_t e, o;
    logic [31:0] insts [17];
    logic [1:0]  ops   [17];
    logic        srcs  [17];
    logic [3:0]  exps  [17];
    insts = '{32'h002081B3, 32'h402081B3, 32'h12345237, 32'h4020D1B3, 32'hFFF00093,
              32'h0020D1B3, 32'h002091B3, 32'h0020A1B3, 32'h0020B1B3, 32'h0020C1B3,
              32'h0020E1B3, 32'h0020F1B3, 32'h00208463, 32'h0000A083, 32'h402081B3,
              32'h402081B3, 32'h4030D093};
    ops   = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
              2'b10, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b11};
    srcs  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exps  = '{4'b0000, 4'b0001, 4'b0011, 4'b1010, 4'b0000, 4'b1000, 4'b1001, 4'b1101,
              4'b1111, 4'b0111, 4'b0100, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 4'b0000,
              4'b1010};
    for (int i = 0; i < 17; i++) begin
      ex_inst    = insts[i];
      ex_alu_op  = ops[i];
      ex_alu_src = srcs[i];
      exp_q.push_back(mk($sformatf("alu_sel[%0d]", i), {28'b0, exps[i]}));
      #1;
      obs_q.push_back(mk($sformatf("alu_sel[%0d]", i), {28'b0, alu_sel}));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no observation, expected %h", e.name, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.val !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
        end
      end
    end
  endtask

  task automatic test_ram_widths();
    item_t e, o;
    ram_write(32'd8, 32'hDEADBEEF, 2'b00);
    ram_read("word_wr", 32'd8, 32'hDEADBEEF);
    ram_write(32'd9, 32'hFFFFFF11, 2'b10);
    ram_read("byte_wr", 32'd8, 32'hDEAD11EF);
    ram_write(32'd10, 32'hAAAA1234, 2'b01);
    ram_read("half_wr", 32'd8, 32'h123411EF);
    ram_write(32'd16, 32'h01020304, 2'b11);
    ram_read("word_sm11", 32'd16, 32'h01020304);
    @(negedge clk);
    dm_read = 1'b0;
    dm_addr = 32'd8;
    exp_q.push_back(mk("read_disabled", 32'h0));
    #1;
    obs_q.push_back(mk("read_disabled", dm_rdata));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no observation, expected %h", e.name, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.val !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    item_t e, o;
    // Read and write the same word in one cycle: old data before the edge, new after.
    @(negedge clk);
    dm_read        = 1'b1;
    dm_write       = 1'b1;
    dm_addr        = 32'd8;
    dm_wdata       = 32'hCAFEF00D;
    dm_save_method = 2'b00;
    exp_q.push_back(mk("rw_before_edge", 32'h123411EF));
    #1;
    obs_q.push_back(mk("rw_before_edge", dm_rdata));
    @(posedge clk);
    #1;
    exp_q.push_back(mk("rw_after_edge", 32'hCAFEF00D));
    obs_q.push_back(mk("rw_after_edge", dm_rdata));
    dm_write = 1'b0;
    ram_read("misaligned", 32'd9, 32'h00CAFEF0);
    // Byte stores on consecutive cycles with write held high.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dm_read        = 1'b0;
      dm_write       = 1'b1;
      dm_addr        = 32'h40 + 32'(i);
      dm_wdata       = 32'(8'h11 * (i + 1));
      dm_save_method = 2'b10;
    end
    @(posedge clk);
    #1 dm_write = 1'b0;
    ram_read("b2b_bytes", 32'h40, 32'h44332211);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no observation, expected %h", e.name, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.val !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
        end
      end
    end
  endtask

  task automatic test_wrap_reset();
    item_t e, o;
    ram_write(32'h3FE, 32'hAABBCCDD, 2'b00);
    ram_read("wrap_low", 32'h0, 32'h0000AABB);
    ram_read("wrap_high_addr_bits", 32'hFFFFF3FE, 32'hAABBCCDD);
    // Asynchronous reset pulse between clock edges.
    @(negedge clk);
    dm_read = 1'b1;
    dm_addr = 32'h3FE;
    #1 rst = 1'b0;
    #1;
    exp_q.push_back(mk("rdata_in_reset", 32'h0));
    obs_q.push_back(mk("rdata_in_reset", dm_rdata));
    #1 rst = 1'b1;
    #1;
    exp_q.push_back(mk("cleared_3fe", 32'h0));
    obs_q.push_back(mk("cleared_3fe", dm_rdata));
    ram_read("cleared_8", 32'd8, 32'h0);
    // Reset asserted mid-write cancels the write.
    @(negedge clk);
    dm_read        = 1'b0;
    dm_write       = 1'b1;
    dm_addr        = 32'h20;
    dm_wdata       = 32'h55555555;
    dm_save_method = 2'b00;
    #3 rst = 1'b0;
    @(posedge clk);
    #1 dm_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ram_read("write_cancelled", 32'h20, 32'h0);
    ram_write(32'h20, 32'h12345678, 2'b00);
    ram_read("write_after_reset", 32'h20, 32'h12345678);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s: no observation, expected %h", e.name, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o.val !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_alu_sel();
    test_ram_widths();
    test_back_to_back();
    test_wrap_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_ctrl_datamem.md
# riscv_ctrl_datamem

Combined decode/execute-control and data-memory block for the 5-stage pipelined RV32I core. The ID stage uses it to turn the instruction into pipeline control signals. The EX stage uses it to turn the latched instruction and ALUOp into a 4-bit ALU select. The MEM stage uses it as a byte-addressed data RAM with word, half and byte stores. Decoders are purely combinational; only the RAM holds state.

## Interface
Parameters:
- ADDR_W, default 10: RAM address width; RAM holds 2^ADDR_W bytes.

Ports:
- clk, input, 1: the single clock; RAM writes happen on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- id_inst, input, 32: instruction in the ID stage.
- branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, output, 1 each: ID control signals.
- alu_op, output, 2: ALU operation class. 00 = add, 01 = branch-compare, 10 = R-type, 11 = I-ALU.
- mux_rf_sel, output, 1: ALU A-operand source. 1 = rs1, 0 = PC.
- auipc_sel, output, 1: write-back source select. 1 = PC+4.
- save_method, output, 2: store width. 00 = word, 01 = half, 10 = byte.
- jump, jalr, output, 1 each: jump-type flags.
- load_pc, output, 1: 0 on a halting instruction.
- ex_inst, input, 32: instruction in the EX stage.
- ex_alu_op, input, 2: ALUOp latched into the EX stage.
- ex_alu_src, input, 1: ALUSrc latched into the EX stage.
- alu_sel, output, 4: ALU function select.
- dm_read, input, 1: RAM read enable.
- dm_write, input, 1: RAM write enable.
- dm_save_method, input, 2: store width for the current write.
- dm_addr, input, 32: byte address.
- dm_wdata, input, 32: store data.
- dm_rdata, output, 32: read data.

## Operation
Control decode uses id_inst[6:0]. Any output not listed below is 0. mux_rf_sel is 1 and load_pc is 1 unless stated otherwise.
- R-type (0110011): reg_write=1, alu_op=10.
- I-ALU (0010011): reg_write=1, alu_src=1, alu_op=11.
- Load (0000011): mem_read=1, mem_to_reg=1, reg_write=1, alu_src=1, alu_op=00.
- Store (0100011): mem_write=1, alu_src=1, alu_op=00.
  - save_method comes from funct3: 000 → 10, 001 → 01, 010 → 00.
  - save_method is 00 for all non-store instructions.
- Branch (1100011): branch=1, alu_op=01.
- JAL (1101111): jump=1, reg_write=1, auipc_sel=1.
- JALR (1100111): jump=1, jalr=1, reg_write=1, auipc_sel=1, alu_src=1, alu_op=00.
- LUI (0110111): reg_write=1, alu_src=1, alu_op=00.
- AUIPC (0010111): reg_write=1, alu_src=1, alu_op=00, mux_rf_sel=0.
- SYSTEM (1110011) and FENCE (0001111): all controls 0, load_pc=0.
- Any other opcode: all controls 0, load_pc=1.

ALU select encodings:
- 0000 ADD, 0001 SUB, 0011 PASS-B, 0100 OR, 0101 AND, 0111 XOR.
- 1000 SRL, 1001 SLL, 1010 SRA, 1101 SLT, 1111 SLTU.

ALU control uses f3 = ex_inst[14:12] and b30 = ex_inst[30]:
- alu_op 00: ADD. Exception: if ex_inst[6:0] is LUI, PASS-B.
- alu_op 01: SUB.
- alu_op 10 or 11, by f3:
  - 000: SUB only when alu_op=10, b30=1 and ex_alu_src=0; otherwise ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRA if b30=1, else SRL.
  - 110 OR, 111 AND.

Data RAM:
- Byte array mem[0 .. 2^ADDR_W-1], little-endian.
- Let a = dm_addr[ADDR_W-1:0]. Every byte index a+k wraps modulo 2^ADDR_W.
- Read: dm_rdata = {mem[a+3], mem[a+2], mem[a+1], mem[a]} when dm_read=1, otherwise 32'h0. The read is combinational.
- Load sign/zero extension happens downstream, not in this block.
- Write on a rising clk edge when dm_write=1:
  - dm_save_method 00 or 11: 4 bytes to a .. a+3.
  - 01: dm_wdata[15:0] to a, a+1.
  - 10: dm_wdata[7:0] to a.
- Misaligned addresses are legal; no alignment trap.

## Timing
- Control decode and alu_sel are combinational, zero latency. They have no reset dependence.
- RAM write takes effect at the rising edge. A same-cycle read of that address returns the old data before the edge and the new data after it.
- rst=0 asynchronously clears every RAM byte to 0 and blocks writes while it is held. dm_rdata reads 0 during reset.
- Reset asserted in the middle of a write cycle cancels that write.
- If dm_read and dm_write are both high, both happen; the read follows the rule above.

## Test plan
- id_inst=0x002081B3 (add) → reg_write=1, alu_op=10, others 0, mux_rf_sel=1, load_pc=1. With ex_inst the same and ex_alu_op=10 → alu_sel=0000. With ex_inst=0x402081B3 → alu_sel=0001.
- id_inst=0x12345237 (lui) → reg_write=1, alu_src=1, alu_op=00. With ex_inst the same and ex_alu_op=00 → alu_sel=0011.
- id_inst=0x00000073 (ecall) → load_pc=0, all other controls 0. id_inst=0x0000006F (jal) → jump=1, reg_write=1, auipc_sel=1.
- Shift and I-type cases:
  - ex_inst=0x4020D1B3 (sra), ex_alu_op=10 → alu_sel=1010.
  - ex_inst=0xFFF00093 (addi), ex_alu_op=11, ex_alu_src=1 → alu_sel=0000, even though bit 30 is 1.
- RAM byte/half/word sequence:
  - Write word 0xDEADBEEF to address 8 with save_method 00.
  - Read address 8 → 0xDEADBEEF.
  - Write byte 0x11 to address 9 with save_method 10.
  - Read address 8 → 0xDEAD11EF.
  - Write half 0x1234 to address 10 with save_method 01.
  - Read address 8 → 0x123411EF.
- Reset and wrap:
  - Write word 0xAABBCCDD to address 0x3FE; bytes wrap to 0x000 and 0x001.
  - Read address 0 → 0x0000AABB.
  - Pulse rst=0 asynchronously, with no clock edge.
  - Read address 0x3FE → 0x00000000.
